frame_ram: RTL

FRAME_RAM -- requirements
Module: frame_ram

---
 rtl/frame_ram.sv | 109 ++++++++++
 1 files changed

// File: rtl/frame_ram.sv
// Single-clock frame buffer with registered reads and a sequential clear engine.
// Out-of-range writes are dropped and out-of-range reads return zero.
module frame_ram #(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 14,
    parameter int              DEPTH     = 16384,
    parameter                  INIT_FILE = "",
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LP_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_done;

    logic w_busy;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_busy   = (r_state == CLEAR);
    assign w_wr_ok  = w_en && !w_busy && ({1'b0, w_addr} < LP_DEPTH);
    assign w_rd_ok  = {1'b0, r_addr} < LP_DEPTH;
    assign clr_busy = w_busy;
    assign clr_done = r_done;

    // Array has no reset so an aborted clear leaves untouched words intact.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_ptr[IDX_W-1:0]] <= CLEAR_VAL;
        end else if (w_wr_ok) begin
            r_mem[w_addr[IDX_W-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ptr <= '0;
                    if (clr_start) begin
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (r_ptr == LP_LAST) begin
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // Forward same-cycle writes (user or clear) so reads are write-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_en;
            if (r_en) begin
                if (!w_rd_ok) begin
                    r_data <= '0;
                end else if (w_busy && (r_addr == r_ptr)) begin
                    r_data <= CLEAR_VAL;
                end else if (w_wr_ok && (w_addr == r_addr)) begin
                    r_data <= w_data;
                end else begin
                    r_data <= r_mem[r_addr[IDX_W-1:0]];
                end
            end
        end
    end

endmodule
